// File: rtl/wash_unit_timer.sv
// rtl/wash_unit_timer.sv - unit time-base with prescaler, saturating unit counter and threshold flags
module wash_unit_timer #(
  parameter int TICKS_PER_UNIT = 100,
  parameter int UNIT_W         = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reset_timer,
  input  logic              timer_stop,
  output logic              done_1u,
  output logic              done_2u,
  output logic              done_5u,
  output logic [UNIT_W-1:0] unit_count,
  output logic              unit_tick
);

  // Prescaler width; a single-tick unit still needs a 1-bit register that simply stays 0.
  localparam int PRE_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICKS_PER_UNIT - 1);
  localparam logic [UNIT_W-1:0] UNIT_MAX = {UNIT_W{1'b1}};

  logic [PRE_W-1:0] prescaler;
  logic             unit_edge;

  // A unit boundary is reached on a run edge whose prescaler sits at its last tick.
  assign unit_edge = (prescaler == PRE_MAX);

  // Prescaler: clear beats stop, stop freezes partial-unit progress, otherwise wrap per unit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
    end else if (!reset_timer) begin
      prescaler <= '0;
    end else if (timer_stop) begin
      prescaler <= prescaler;
    end else if (unit_edge) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  // Unit counter saturates at all-ones; the tick still pulses at every unit boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      unit_count <= '0;
      unit_tick  <= 1'b0;
    end else if (!reset_timer) begin
      unit_count <= '0;
      unit_tick  <= 1'b0;
    end else if (timer_stop) begin
      unit_count <= unit_count;
      unit_tick  <= 1'b0;
    end else if (unit_edge) begin
      unit_count <= (unit_count == UNIT_MAX) ? UNIT_MAX : unit_count + UNIT_W'(1);
      unit_tick  <= 1'b1;
    end else begin
      unit_count <= unit_count;
      unit_tick  <= 1'b0;
    end
  end

  // Threshold flags decode the registered count directly so a clear is visible next cycle.
  always_comb begin
    done_1u = (unit_count >= UNIT_W'(1));
    done_2u = (unit_count >= UNIT_W'(2));
    done_5u = (unit_count >= UNIT_W'(5));
  end

endmodule

// File: tb/tb_wash_unit_timer.sv
// tb/tb_wash_unit_timer.sv - self-checking bench for wash_unit_timer
module tb_wash_unit_timer;

  localparam int TPU = 4;
  localparam int UW  = 3;
  localparam int MAXU = (1 << UW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          reset_timer = 1'b0;
  logic          timer_stop = 1'b0;
  logic          done_1u, done_2u, done_5u;
  logic [UW-1:0] unit_count;
  logic          unit_tick;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: total counted run edges since last clear, and last-edge tick.
  int m_runs = 0;
  int m_tick = 0;

  wash_unit_timer #(.TICKS_PER_UNIT(TPU), .UNIT_W(UW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .reset_timer(reset_timer),
    .timer_stop (timer_stop),
    .done_1u    (done_1u),
    .done_2u    (done_2u),
    .done_5u    (done_5u),
    .unit_count (unit_count),
    .unit_tick  (unit_tick)
  );

  always #5 clk = ~clk;

  function automatic int m_count();
    int u;
    u = m_runs / TPU;
    return (u > MAXU) ? MAXU : u;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: elapsed units are run edges divided by ticks per unit, capped.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_runs = 0;
      m_tick = 0;
    end else if (!reset_timer) begin
      m_runs = 0;
      m_tick = 0;
    end else if (timer_stop) begin
      m_tick = 0;
    end else begin
      m_runs = m_runs + 1;
      m_tick = ((m_runs % TPU) == 0) ? 1 : 0;
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_unit_count", 32'(unit_count), 32'(m_count()));
    chk("cyc_unit_tick",  32'(unit_tick),  32'(m_tick));
    chk("cyc_done_1u",    32'(done_1u),    32'(m_count() >= 1));
    chk("cyc_done_2u",    32'(done_2u),    32'(m_count() >= 2));
    chk("cyc_done_5u",    32'(done_5u),    32'(m_count() >= 5));
  end

  task automatic step(input logic rt, input logic ts);
    reset_timer = rt;
    timer_stop  = ts;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int iters;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(unit_count), 0);
    chk("rst_tick",  32'(unit_tick), 0);
    chk("rst_done1", 32'(done_1u), 0);
    reset_n = 1'b1;

    // T1 basic count
    step(1'b0, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      step(1'b1, 1'b0);
      if (e == 3)  chk("t1_done1_e3", 32'(done_1u), 0);
      if (e == 4)  begin chk("t1_done1_e4", 32'(done_1u), 1); chk("t1_tick_e4", 32'(unit_tick), 1); end
      if (e == 5)  chk("t1_tick_e5", 32'(unit_tick), 0);
      if (e == 7)  chk("t1_done2_e7", 32'(done_2u), 0);
      if (e == 8)  chk("t1_done2_e8", 32'(done_2u), 1);
      if (e == 19) chk("t1_done5_e19", 32'(done_5u), 0);
      if (e == 20) begin chk("t1_done5_e20", 32'(done_5u), 1); chk("t1_count_e20", 32'(unit_count), 5); end
    end

    // T2 pause preserves partial progress
    step(1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b0);
    chk("t2_count_run6", 32'(unit_count), 1);
    repeat (10) step(1'b1, 1'b1);
    chk("t2_count_frozen", 32'(unit_count), 1);
    chk("t2_tick_frozen", 32'(unit_tick), 0);
    step(1'b1, 1'b0);
    chk("t2_count_r1", 32'(unit_count), 1);
    step(1'b1, 1'b0);
    chk("t2_count_r2", 32'(unit_count), 2);
    chk("t2_done2", 32'(done_2u), 1);

    // T3 clear beats stop
    repeat (4) step(1'b1, 1'b0);
    chk("t3_count3", 32'(unit_count), 3);
    step(1'b0, 1'b1);
    chk("t3_count_clr", 32'(unit_count), 0);
    chk("t3_done1_clr", 32'(done_1u), 0);
    chk("t3_done2_clr", 32'(done_2u), 0);
    repeat (3) step(1'b1, 1'b0);
    chk("t3_pre_cleared", 32'(unit_count), 0);
    step(1'b1, 1'b0);
    chk("t3_first_unit", 32'(unit_count), 1);

    // T4 saturation
    step(1'b0, 1'b0);
    for (int e = 1; e <= 40; e++) begin
      step(1'b1, 1'b0);
      if (e == 27) chk("t4_count_e27", 32'(unit_count), 6);
      if (e == 28) chk("t4_count_e28", 32'(unit_count), 7);
      if (e == 32) begin chk("t4_tick_e32", 32'(unit_tick), 1); chk("t4_count_e32", 32'(unit_count), 7); end
      if (e == 40) begin chk("t4_count_e40", 32'(unit_count), 7); chk("t4_done5_e40", 32'(done_5u), 1); end
    end

    // T5 async reset mid-count
    step(1'b0, 1'b0);
    repeat (9) step(1'b1, 1'b0);
    chk("t5_count2", 32'(unit_count), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_count", 32'(unit_count), 0);
    chk("t5_async_done1", 32'(done_1u), 0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) step(1'b1, 1'b0);
    chk("t5_done1_e3", 32'(done_1u), 0);
    step(1'b1, 1'b0);
    chk("t5_done1_e4", 32'(done_1u), 1);

    // T6 FSM handshake
    step(1'b0, 1'b0);
    iters = 0;
    while (!done_2u && iters < 50) begin
      step(1'b1, 1'b0);
      iters++;
    end
    chk("t6_edges_to_done2", 32'(iters), 8);
    step(1'b0, 1'b0);
    chk("t6_done2_dropped", 32'(done_2u), 0);
    repeat (7) step(1'b1, 1'b0);
    chk("t6_done2_e7", 32'(done_2u), 0);
    step(1'b1, 1'b0);
    chk("t6_done2_e8", 32'(done_2u), 1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
